// File: rtl/macarray_ctrl.sv
// Sequencer for the 8x8 MAC-array matmul: latches M/N/T, streams weight and
// input rows from SRAM through two 4-column tiles, and writes 16 result words.
module macarray_ctrl #(
    parameter int unsigned PIPE_LAT = 4,
    parameter int unsigned AW       = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [11:0]   i_mnt,
    output logic          o_en_w,
    output logic [AW-1:0] o_addr_w,
    output logic          o_en_i,
    output logic [AW-1:0] o_addr_i,
    output logic          o_en_o,
    output logic          o_rw_o,
    output logic [AW-1:0] o_addr_o,
    output logic          o_w_load,
    output logic [1:0]    o_w_idx,
    output logic          o_w_zero,
    output logic          o_i_valid,
    output logic [2:0]    o_i_row,
    output logic          o_i_zero,
    output logic          o_acc_clr,
    output logic [2:0]    o_o_row,
    output logic          o_o_zero,
    output logic [7:0]    o_k_mask,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LDW,
        S_STREAM,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [7:0] DRAIN_LAST = 8'(PIPE_LAT - 1);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic       r_k, w_k_nxt;
    logic       r_start_q;
    logic [3:0] r_m, r_n, r_t;
    logic       r_err;
    logic       r_w_load, r_w_zero, r_i_valid, r_i_zero;
    logic [1:0] r_w_idx;
    logic [2:0] r_i_row;

    logic       w_accept, w_legal;
    logic [2:0] w_col, w_row;
    logic       w_col_live, w_row_live, w_tile_dead;

    function automatic logic f_legal(input logic [3:0] f);
        return (f != 4'd0) && (f <= 4'd8);
    endfunction

    assign w_accept    = (r_state == S_IDLE) && i_start && !r_start_q;
    assign w_legal     = f_legal(i_mnt[11:8]) && f_legal(i_mnt[7:4]) && f_legal(i_mnt[3:0]);
    assign w_col       = {r_k, r_cnt[1:0]};
    assign w_row       = r_cnt[2:0];
    assign w_col_live  = {1'b0, w_col} < r_m;
    assign w_row_live  = {1'b0, w_row} < r_t;
    // Whole second tile lies beyond M: every result column there is zero.
    assign w_tile_dead = r_k && (r_m <= 4'd4);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 8'd1;
        w_k_nxt     = r_k;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_k_nxt   = 1'b0;
                if (w_accept)
                    w_state_nxt = w_legal ? S_LDW : S_DONE;
            end
            S_LDW: begin
                if (r_cnt == 8'd3) begin
                    w_state_nxt = S_STREAM;
                    w_cnt_nxt   = '0;
                end
            end
            S_STREAM: begin
                if (r_cnt == 8'd7) begin
                    w_state_nxt = S_DRAIN;
                    w_cnt_nxt   = '0;
                end
            end
            S_DRAIN: begin
                if (r_cnt == DRAIN_LAST) begin
                    w_state_nxt = S_WRITE;
                    w_cnt_nxt   = '0;
                end
            end
            S_WRITE: begin
                if (r_cnt == 8'd7) begin
                    w_state_nxt = r_k ? S_DONE : S_LDW;
                    w_cnt_nxt   = '0;
                    w_k_nxt     = ~r_k;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        o_en_w    = 1'b0;
        o_addr_w  = '0;
        o_en_i    = 1'b0;
        o_addr_i  = '0;
        o_en_o    = 1'b0;
        o_rw_o    = 1'b0;
        o_addr_o  = '0;
        o_acc_clr = 1'b0;
        o_o_row   = '0;
        o_o_zero  = 1'b0;
        o_done    = 1'b0;
        case (r_state)
            S_LDW: begin
                o_en_w    = w_col_live;
                o_addr_w  = w_col_live ? AW'(w_col) : '0;
                o_acc_clr = (r_cnt == 8'd0);
            end
            S_STREAM: begin
                o_en_i   = w_row_live;
                o_addr_i = w_row_live ? AW'(w_row) : '0;
            end
            S_WRITE: begin
                o_en_o   = 1'b1;
                o_rw_o   = 1'b1;
                o_addr_o = AW'({r_k, w_row});
                o_o_row  = w_row;
                o_o_zero = !w_row_live || w_tile_dead;
            end
            S_DONE:  o_done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < 8; i++)
            o_k_mask[i] = 4'(i) < r_n;
    end

    assign o_busy    = (r_state == S_LDW) || (r_state == S_STREAM) ||
                       (r_state == S_DRAIN) || (r_state == S_WRITE);
    assign o_err     = r_err;
    assign o_w_load  = r_w_load;
    assign o_w_idx   = r_w_idx;
    assign o_w_zero  = r_w_zero;
    assign o_i_valid = r_i_valid;
    assign o_i_row   = r_i_row;
    assign o_i_zero  = r_i_zero;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_k       <= 1'b0;
            r_start_q <= 1'b0;
            r_m       <= '0;
            r_n       <= '0;
            r_t       <= '0;
            r_err     <= 1'b0;
            r_w_load  <= 1'b0;
            r_w_idx   <= '0;
            r_w_zero  <= 1'b0;
            r_i_valid <= 1'b0;
            r_i_row   <= '0;
            r_i_zero  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_k       <= w_k_nxt;
            r_start_q <= i_start;
            if (w_accept) begin
                r_m   <= i_mnt[11:8];
                r_n   <= i_mnt[7:4];
                r_t   <= i_mnt[3:0];
                r_err <= !w_legal;
            end
            // SRAM data arrives one cycle after the enable, so the datapath strobes trail the issue.
            r_w_load  <= (r_state == S_LDW);
            r_w_idx   <= (r_state == S_LDW) ? r_cnt[1:0] : '0;
            r_w_zero  <= (r_state == S_LDW) && !w_col_live;
            r_i_valid <= (r_state == S_STREAM);
            r_i_row   <= (r_state == S_STREAM) ? w_row : '0;
            r_i_zero  <= (r_state == S_STREAM) && !w_row_live;
        end
    end

endmodule

// File: tb/tb_macarray_ctrl.sv
// Directed self-checking bench for macarray_ctrl: legal/illegal runs, START
// edge handling, and asynchronous reset mid-run.
module tb_macarray_ctrl;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic [11:0] i_mnt;
    logic        o_en_w, o_en_i, o_en_o, o_rw_o;
    logic [3:0]  o_addr_w, o_addr_i, o_addr_o;
    logic        o_w_load, o_w_zero, o_i_valid, o_i_zero, o_acc_clr, o_o_zero;
    logic [1:0]  o_w_idx;
    logic [2:0]  o_i_row, o_o_row;
    logic [7:0]  o_k_mask;
    logic        o_busy, o_done, o_err;
    logic [40:0] w_all;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc_now  = 0;
    int acc      = 0;
    int lat      = 0;

    int n_w, n_i, n_o, n_wload, n_ivalid, n_wz, n_iz, n_clr, n_busy, n_done, n_multi, n_seq_bad;
    logic [15:0] w_mask, i_mask, o_mask, oz_mask;
    logic        p_en_w, p_en_i;
    logic [3:0]  p_addr_w, p_addr_i;

    macarray_ctrl #(.PIPE_LAT(4), .AW(4)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_mnt(i_mnt),
        .o_en_w(o_en_w), .o_addr_w(o_addr_w), .o_en_i(o_en_i), .o_addr_i(o_addr_i),
        .o_en_o(o_en_o), .o_rw_o(o_rw_o), .o_addr_o(o_addr_o),
        .o_w_load(o_w_load), .o_w_idx(o_w_idx), .o_w_zero(o_w_zero),
        .o_i_valid(o_i_valid), .o_i_row(o_i_row), .o_i_zero(o_i_zero),
        .o_acc_clr(o_acc_clr), .o_o_row(o_o_row), .o_o_zero(o_o_zero),
        .o_k_mask(o_k_mask), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    assign w_all = {o_en_w, o_addr_w, o_en_i, o_addr_i, o_en_o, o_rw_o, o_addr_o,
                    o_w_load, o_w_idx, o_w_zero, o_i_valid, o_i_row, o_i_zero,
                    o_acc_clr, o_o_row, o_o_zero, o_k_mask, o_busy, o_done, o_err};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        n_w = 0; n_i = 0; n_o = 0; n_wload = 0; n_ivalid = 0; n_wz = 0; n_iz = 0;
        n_clr = 0; n_busy = 0; n_done = 0; n_multi = 0; n_seq_bad = 0;
        w_mask = '0; i_mask = '0; o_mask = '0; oz_mask = '0;
        p_en_w = 1'b0; p_en_i = 1'b0; p_addr_w = '0; p_addr_i = '0;
    endtask

    // One clock; sample 1 time unit after the edge and accumulate run statistics.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc_now++;
        if (o_en_w) begin n_w++; w_mask[o_addr_w] = 1'b1; end
        if (o_en_i) begin n_i++; i_mask[o_addr_i] = 1'b1; end
        if (o_en_o) begin
            n_o++;
            o_mask[o_addr_o] = 1'b1;
            if (o_o_zero) oz_mask[o_addr_o] = 1'b1;
            if (!o_rw_o || o_o_row != o_addr_o[2:0]) n_seq_bad++;
        end
        if (o_w_load) n_wload++;
        if (o_i_valid) n_ivalid++;
        if (o_w_load && o_w_zero) n_wz++;
        if (o_i_valid && o_i_zero) n_iz++;
        if (o_w_zero && !o_w_load) n_seq_bad++;
        if (o_i_zero && !o_i_valid) n_seq_bad++;
        if (p_en_w && !(o_w_load && !o_w_zero && o_w_idx == p_addr_w[1:0])) n_seq_bad++;
        if (o_w_load && !o_w_zero && !p_en_w) n_seq_bad++;
        if (p_en_i && !(o_i_valid && !o_i_zero && o_i_row == p_addr_i[2:0])) n_seq_bad++;
        if (o_i_valid && !o_i_zero && !p_en_i) n_seq_bad++;
        if (o_acc_clr) n_clr++;
        if (o_busy) n_busy++;
        if (o_done) n_done++;
        if (32'(o_en_w) + 32'(o_en_i) + 32'(o_en_o) > 1) n_multi++;
        p_en_w = o_en_w; p_addr_w = o_addr_w;
        p_en_i = o_en_i; p_addr_i = o_addr_i;
    endtask

    task automatic start_run(input logic [11:0] mnt);
        clear_stats();
        i_mnt   = mnt;
        i_start = 1'b1;
        tick();
        acc = cyc_now;
    endtask

    task automatic wait_done();
        while (!o_done && (cyc_now - acc) < 200) tick();
        lat = cyc_now - acc;
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_mnt   = '0;
        clear_stats();
        #12;
        check("reset_outputs", 64'(w_all), 64'd0);
        #10 i_rst_n = 1'b1;
        repeat (3) tick();
        check("idle_no_busy", 64'(n_busy), 64'd0);

        // 1: M=N=T=3
        start_run(12'h333);
        wait_done();
        check("t1_latency", 64'(lat), 64'd48);
        check("t1_busy_cycles", 64'(n_busy), 64'd48);
        check("t1_n_w", 64'(n_w), 64'd3);
        check("t1_w_mask", 64'(w_mask), 64'h0007);
        check("t1_n_i", 64'(n_i), 64'd6);
        check("t1_i_mask", 64'(i_mask), 64'h0007);
        check("t1_o_mask", 64'(o_mask), 64'hFFFF);
        check("t1_n_o", 64'(n_o), 64'd16);
        check("t1_oz_mask", 64'(oz_mask), 64'hFFF8);
        check("t1_wload_ivalid", 64'({n_wload, n_ivalid}), {32'd8, 32'd16});
        check("t1_wz_iz", 64'({n_wz, n_iz}), {32'd5, 32'd10});
        check("t1_acc_clr", 64'(n_clr), 64'd2);
        check("t1_multi_en", 64'(n_multi), 64'd0);
        check("t1_seq", 64'(n_seq_bad), 64'd0);
        check("t1_k_mask", 64'(o_k_mask), 64'h07);
        check("t1_err", 64'(o_err), 64'd0);
        i_start = 1'b0;
        tick();
        check("t1_done_pulse", 64'({o_done, o_busy}), 64'd0);

        // 2: full 8x8x8
        start_run(12'h888);
        wait_done();
        check("t2_latency", 64'(lat), 64'd48);
        check("t2_n_w", 64'(n_w), 64'd8);
        check("t2_w_mask", 64'(w_mask), 64'h00FF);
        check("t2_n_i", 64'(n_i), 64'd16);
        check("t2_i_mask", 64'(i_mask), 64'h00FF);
        check("t2_zero_flags", 64'({n_wz, n_iz}), 64'd0);
        check("t2_oz_mask", 64'(oz_mask), 64'h0000);
        check("t2_o_mask", 64'(o_mask), 64'hFFFF);
        check("t2_k_mask", 64'(o_k_mask), 64'hFF);
        check("t2_seq", 64'(n_seq_bad), 64'd0);
        i_start = 1'b0;
        tick();

        // 3: M=4 N=1 T=8, second tile entirely empty
        start_run(12'h418);
        wait_done();
        check("t3_n_w", 64'(n_w), 64'd4);
        check("t3_w_mask", 64'(w_mask), 64'h000F);
        check("t3_wz", 64'(n_wz), 64'd4);
        check("t3_iz", 64'(n_iz), 64'd0);
        check("t3_oz_mask", 64'(oz_mask), 64'hFF00);
        check("t3_k_mask", 64'(o_k_mask), 64'h01);
        check("t3_seq", 64'(n_seq_bad), 64'd0);
        i_start = 1'b0;
        tick();

        // 4: illegal M=0, then a legal run clears ERR
        start_run(12'h033);
        check("t4_err_set", 64'(o_err), 64'd1);
        wait_done();
        check("t4_latency", 64'(lat), 64'd0);
        check("t4_no_sram", 64'(n_w + n_i + n_o), 64'd0);
        check("t4_no_busy", 64'(n_busy), 64'd0);
        i_start = 1'b0;
        tick();
        check("t4_err_sticky", 64'({o_err, o_done}), 64'h2);
        start_run(12'h111);
        check("t4_err_cleared", 64'(o_err), 64'd0);
        wait_done();
        check("t4_legal_latency", 64'(lat), 64'd48);
        check("t4_w_mask", 64'(w_mask), 64'h0001);
        check("t4_oz_mask", 64'(oz_mask), 64'hFFFE);
        i_start = 1'b0;
        tick();

        // 5: START held high, MNT changed mid-run
        start_run(12'h222);
        repeat (10) tick();
        i_mnt = 12'h888;
        wait_done();
        check("t5_latency", 64'(lat), 64'd48);
        check("t5_w_mask", 64'(w_mask), 64'h0003);
        check("t5_i_mask", 64'(i_mask), 64'h0003);
        check("t5_n_i", 64'(n_i), 64'd4);
        check("t5_oz_mask", 64'(oz_mask), 64'hFFFC);
        check("t5_k_mask", 64'(o_k_mask), 64'h03);
        clear_stats();
        repeat (200) tick();
        check("t5_no_retrigger", 64'(n_w + n_i + n_o + n_busy + n_done), 64'd0);
        i_start = 1'b0;
        tick();

        // 6: asynchronous reset during tile-0 WRITE
        start_run(12'h888);
        i_start = 1'b0;
        for (int i = 0; i < 100 && !o_en_o; i++) tick();
        check("t6_reached_write", 64'({o_en_o, o_addr_o}), 64'h10);
        repeat (2) tick();
        check("t6_write_addr", 64'(o_addr_o), 64'd2);
        #2 i_rst_n = 1'b0;
        #1;
        check("t6_async_reset", 64'(w_all), 64'd0);
        #3 i_rst_n = 1'b1;
        clear_stats();
        repeat (20) tick();
        check("t6_quiet_after_reset", 64'(n_w + n_i + n_o + n_busy + n_done), 64'd0);
        start_run(12'h888);
        wait_done();
        check("t6_restart_latency", 64'(lat), 64'd48);
        check("t6_restart_n_w", 64'(n_w), 64'd8);
        i_start = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
